risc_toy_fetch_unit: RTL and testbench

//  Instruction fetch front end for the 5-stage toy RISC pipeline; replaces the free-running PC+4 IF stage.

---
 rtl/risc_toy_fetch_unit.sv | 122 ++++++++++++
 tb/tb_risc_toy_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_fetch_unit.sv
// Instruction fetch front end for the toy RISC pipeline.
// Issues one-word requests to a 1-cycle synchronous IMEM. Returned words go into
// a small prefetch FIFO that feeds ID through a valid/ready handshake. A PC
// redirect flushes the FIFO and any in-flight response.
module risc_toy_fetch_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        MEM_ADDR_W = 10,
  parameter int unsigned        DEPTH      = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  imem_ce,
  output logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [31:0]           id_instr,
  output logic [ADDR_W-1:0]     id_pc,
  output logic [ADDR_W-1:0]     dbg_fetch_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [OCC_W-1:0]  occ;

  // Low two bits of the redirect target are architecturally ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake, occupancy-based issue gating and return path.
  always_comb begin
    pop   = id_valid & id_ready;
    occ   = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue = rst_n & ~redirect_valid & (occ < OCC_W'(DEPTH));
    push  = inflight_q & ~redirect_valid;
  end

  // Output views of the fetch PC and FIFO head; head fields read as zero when empty.
  always_comb begin
    imem_ce      = issue;
    imem_addr    = pc_q[MEM_ADDR_W+1:2];
    id_valid     = (count_q != '0);
    id_instr     = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    id_pc        = id_valid ? pc_mem_q[rd_ptr_q] : '0;
    dbg_fetch_pc = pc_q;
  end

  // Next-state logic; redirect overrides every other update.
  always_comb begin
    pc_d       = pc_q;
    ifpc_d     = ifpc_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d       = pc_q + ADDR_W'(4);
        ifpc_d     = pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ifpc_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ifpc_q     <= ifpc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= ifpc_q;
    end
  end

endmodule

// File: tb/tb_risc_toy_fetch_unit.sv
// Directed bench for risc_toy_fetch_unit with a behavioural 1-cycle IMEM holding IMEM[k]=k+0x100.
module tb_risc_toy_fetch_unit;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned DEPTH      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  redirect_valid;
  logic [ADDR_W-1:0]     redirect_pc;
  logic                  imem_ce;
  logic [MEM_ADDR_W-1:0] imem_addr;
  logic [31:0]           imem_rdata;
  logic                  id_valid;
  logic                  id_ready;
  logic [31:0]           id_instr;
  logic [ADDR_W-1:0]     id_pc;
  logic [ADDR_W-1:0]     dbg_fetch_pc;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_instr;

  risc_toy_fetch_unit #(
    .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_ce(imem_ce), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .dbg_fetch_pc(dbg_fetch_pc)
  );

  always #5 clk = ~clk;

  // IMEM model: word k holds k+0x100, data valid the cycle after the request.
  always @(posedge clk) begin
    if (imem_ce) imem_rdata <= 32'h100 + 32'(imem_addr);
  end

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (imem_ce !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", imem_ce); end
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_idpc got=%h exp=0", id_pc); end
    checks++; if (dbg_fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", dbg_fetch_pc); end
  endtask

  // Release reset after an edge; first issue next cycle, first valid after the second edge.
  task automatic test_stream(input int n);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_ce !== 1'b1 || imem_addr !== 10'h0) begin failures++; $display("FAIL first_issue ce=%b addr=%h exp ce=1 addr=0", imem_ce, imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL first_gap0 got=%b exp=0", id_valid); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0 || dbg_fetch_pc !== 32'h4) begin failures++; $display("FAIL first_gap1 valid=%b pc=%h exp valid=0 pc=4", id_valid, dbg_fetch_pc); end
    @(negedge clk);
    exp_pc = 32'h0;
    for (int i = 0; i < n; i++) begin
      exp_instr = 32'h100 + 32'(exp_pc[11:2]);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
        failures++; $display("FAIL stream[%0d] valid=%b pc=%h instr=%h exp pc=%h instr=%h", i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0; #1;
    checks++; if (imem_ce !== 1'b0) begin failures++; $display("FAIL bp_ce_first got=%b exp=0", imem_ce); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || imem_ce !== 1'b0 || dbg_fetch_pc !== exp_pc + 32'h8) begin
        failures++; $display("FAIL bp_hold[%0d] valid=%b pc=%h ce=%b fpc=%h exp pc=%h ce=0 fpc=%h", i, id_valid, id_pc, imem_ce, dbg_fetch_pc, exp_pc, exp_pc + 32'h8);
      end
    end
    id_ready = 1'b1; #1;
    checks++; if (imem_ce !== 1'b1 || 32'(imem_addr) !== ((exp_pc + 32'h8) >> 2)) begin failures++; $display("FAIL bp_resume ce=%b addr=%h exp ce=1", imem_ce, imem_addr); end
    for (int i = 0; i < 6; i++) begin
      exp_instr = 32'h100 + 32'(exp_pc[11:2]);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
        failures++; $display("FAIL bp_order[%0d] valid=%b pc=%h instr=%h exp pc=%h instr=%h", i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end
  endtask

  // Redirect while the FIFO occupancy is at DEPTH (one held, one in flight), head not consumed.
  task automatic test_redirect_full();
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43; #1;
    checks++; if (imem_ce !== 1'b0) begin failures++; $display("FAIL rf_ce got=%b exp=0", imem_ce); end
    @(negedge clk);
    redirect_valid = 1'b0; id_ready = 1'b1; #1;
    checks++; if (id_valid !== 1'b0 || dbg_fetch_pc !== 32'h40) begin failures++; $display("FAIL rf_flush valid=%b pc=%h exp valid=0 pc=40", id_valid, dbg_fetch_pc); end
    checks++; if (imem_ce !== 1'b1 || imem_addr !== 10'h10) begin failures++; $display("FAIL rf_issue ce=%b addr=%h exp ce=1 addr=10", imem_ce, imem_addr); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rf_gap got=%b exp=0", id_valid); end
    @(negedge clk);
    exp_pc = 32'h40;
    for (int i = 0; i < 4; i++) begin
      exp_instr = 32'h100 + 32'(exp_pc[11:2]);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
        failures++; $display("FAIL rf_order[%0d] valid=%b pc=%h instr=%h exp pc=%h instr=%h", i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end
  endtask

  // Redirect in the same cycle as a pop and a returning push.
  task automatic test_redirect_pop();
    checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin failures++; $display("FAIL rp_head valid=%b pc=%h exp pc=%h", id_valid, id_pc, exp_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h80; #1;
    checks++; if (imem_ce !== 1'b0) begin failures++; $display("FAIL rp_ce got=%b exp=0", imem_ce); end
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || dbg_fetch_pc !== 32'h80) begin failures++; $display("FAIL rp_empty valid=%b pc=%h exp valid=0 pc=80", id_valid, dbg_fetch_pc); end
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rp_gap got=%b exp=0", id_valid); end
    @(negedge clk);
    exp_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      exp_instr = 32'h100 + 32'(exp_pc[11:2]);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
        failures++; $display("FAIL rp_order[%0d] valid=%b pc=%h instr=%h exp pc=%h instr=%h", i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0; #1;
    checks++; if (id_valid !== 1'b0 || imem_ce !== 1'b0) begin failures++; $display("FAIL ar_drop valid=%b ce=%b exp 0 0", id_valid, imem_ce); end
    checks++; if (id_pc !== 32'h0 || dbg_fetch_pc !== 32'h0) begin failures++; $display("FAIL ar_pc idpc=%h fpc=%h exp 0 0", id_pc, dbg_fetch_pc); end
    test_stream(4);
  endtask

  // Fetch PC wraps from 2^ADDR_W-4 to 0; redirect target low bits are ignored.
  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    @(negedge clk);
    redirect_valid = 1'b0;
    checks++; if (dbg_fetch_pc !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 got=%h exp=fffffff8", dbg_fetch_pc); end
    @(negedge clk);
    checks++; if (dbg_fetch_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got=%h exp=fffffffc", dbg_fetch_pc); end
    @(negedge clk);
    checks++; if (dbg_fetch_pc !== 32'h0) begin failures++; $display("FAIL wrap_pc2 got=%h exp=0", dbg_fetch_pc); end
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3 * DEPTH + 2; i++) begin
      exp_instr = 32'h100 + 32'(exp_pc[11:2]);
      checks++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== exp_instr) begin
        failures++; $display("FAIL wrap_order[%0d] valid=%b pc=%h instr=%h exp pc=%h instr=%h", i, id_valid, id_pc, id_instr, exp_pc, exp_instr);
      end
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end
  endtask

  // Ready pattern 0,1,1 repeated: FIFO stays non-empty, every ready cycle consumes.
  task automatic test_back_to_back();
    int consumed = 0;
    for (int i = 0; i < 24; i++) begin
      id_ready = ((i % 3) != 0);
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, id_valid); end
      if (id_valid && id_ready) begin
        exp_instr = 32'h100 + 32'(exp_pc[11:2]);
        checks++; if (id_pc !== exp_pc || id_instr !== exp_instr) begin
          failures++; $display("FAIL b2b_order[%0d] pc=%h instr=%h exp pc=%h instr=%h", i, id_pc, id_instr, exp_pc, exp_instr);
        end
        exp_pc = exp_pc + 32'h4;
        consumed++;
      end
      @(negedge clk);
    end
    id_ready = 1'b1;
    checks++; if (consumed != 16) begin failures++; $display("FAIL b2b_count got=%0d exp=16", consumed); end
  endtask

  initial begin
    test_reset();
    test_stream(8);
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_async_reset();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
